burst_line_port: RTL and testbench

Initiator-side adapter that drives the BurstRAM command interface on behalf of a line-oriented client such as a cache. It turns one line read or line write request into a single BurstRAM burst command. It assembles or serialises the BURST_COUNT data beats and returns one response per request. It sits between the cache/CPU memory path and the BurstRAM model or DDR controller.

---
 rtl/burst_line_port_pkg.sv | 26 ++
 rtl/burst_line_port_if.sv | 45 ++++
 rtl/burst_line_port.sv | 174 +++++++++++++++++
 tb/tb_burst_line_port.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_line_port_pkg.sv
// rtl/burst_line_port_pkg.sv - shared types, command codes and beat-count helper for burst_line_port
package burst_line_port_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WR_BEATS,
    ST_RD_BEATS,
    ST_DONE
  } state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // log2 of a power-of-two beat count; also the number of zero bits appended to a line index
  function automatic int beat_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/burst_line_port_if.sv
// rtl/burst_line_port_if.sv - client request/response and BurstRAM command signals of burst_line_port
interface burst_line_port_if
  import burst_line_port_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_COUNT     = 4,
  parameter int ADDR_WIDTH      = 4,
  parameter int LINE_ADDR_WIDTH = ADDR_WIDTH - beat_log2(BURST_COUNT)
);

  // client side
  logic                              req_valid;
  logic                              req_ready;
  logic                              req_write;
  logic [LINE_ADDR_WIDTH-1:0]        req_addr;
  logic [DATA_WIDTH*BURST_COUNT-1:0] req_wdata;
  logic                              resp_valid;
  logic [DATA_WIDTH*BURST_COUNT-1:0] resp_rdata;
  logic                              resp_err;

  // BurstRAM side
  logic                              cmd;
  logic                              cmd_en;
  logic [ADDR_WIDTH-1:0]             addr;
  logic [DATA_WIDTH-1:0]             wr_data;
  logic [DATA_WIDTH/8-1:0]           data_mask;
  logic [DATA_WIDTH-1:0]             rd_data;
  logic                              rd_data_valid;
  logic                              busy;

  // the port itself
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rd_data, rd_data_valid, busy,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output cmd, cmd_en, addr, wr_data, data_mask
  );

  // the client plus the RAM it talks to
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rd_data, rd_data_valid, busy,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  cmd, cmd_en, addr, wr_data, data_mask
  );

endinterface

// File: rtl/burst_line_port.sv
// rtl/burst_line_port.sv - line request to BurstRAM burst adapter (optional watchdog: BURST_LINE_PORT_TIMEOUT_EN)
module burst_line_port
  import burst_line_port_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_COUNT     = 4,
  parameter int ADDR_WIDTH      = 4,
  parameter int LINE_ADDR_WIDTH = ADDR_WIDTH - beat_log2(BURST_COUNT),
  parameter int TIMEOUT_CYCLES  = 64
) (
  input logic               clk,
  input logic               rst,
  burst_line_port_if.master bus_io
);

  localparam int BEAT_LOG = beat_log2(BURST_COUNT);
  localparam int CNT_W    = (BEAT_LOG > 0) ? BEAT_LOG : 1;
  localparam int LINE_W   = DATA_WIDTH * BURST_COUNT;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_COUNT - 1);

  if (BURST_COUNT != (1 << BEAT_LOG)) begin : g_chk_burst
    $error("burst_line_port: BURST_COUNT must be a power of two");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("burst_line_port: TIMEOUT_CYCLES must be at least 2");
  end

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           beat_q, beat_d;
  logic                       wr_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [LINE_W-1:0]          wline_q;
  logic [LINE_W-1:0]          rbuf_q, rbuf_d;
  logic [LINE_W-1:0]          rdata_q;
  logic [LINE_ADDR_WIDTH-1:0] req_line;

  logic                       accept;
  logic                       rd_last;
  logic                       req_ready_c;
  logic                       cmd_en_c;
  logic                       cmd_c;
  logic [DATA_WIDTH-1:0]      wr_data_c;
  logic                       resp_valid_c;

`ifdef BURST_LINE_PORT_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q;
  logic             err_q;
  logic             timeout;
`endif

  assign req_line = bus_io.req_addr;

  // next-state, beat counter, read assembly and strobes
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    rbuf_d       = rbuf_q;
    accept       = 1'b0;
    rd_last      = 1'b0;
    req_ready_c  = 1'b0;
    cmd_en_c     = 1'b0;
    cmd_c        = CMD_READ;
    wr_data_c    = '0;
    resp_valid_c = 1'b0;
`ifdef BURST_LINE_PORT_TIMEOUT_EN
    timeout      = 1'b0;
`endif
    case (state_q)
      ST_INIT: begin
        if (!bus_io.busy) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready_c = !bus_io.busy;
        if (bus_io.req_valid && !bus_io.busy) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cmd_en_c = 1'b1;
        cmd_c    = wr_q ? CMD_WRITE : CMD_READ;
        if (wr_q) begin
          // beat 0 rides along with the command strobe
          wr_data_c = wline_q[DATA_WIDTH-1:0];
          beat_d    = CNT_W'(1);
          state_d   = (BURST_COUNT == 1) ? ST_DONE : ST_WR_BEATS;
        end else begin
          beat_d  = '0;
          state_d = ST_RD_BEATS;
        end
      end
      ST_WR_BEATS: begin
        wr_data_c = wline_q[DATA_WIDTH*int'(beat_q) +: DATA_WIDTH];
        if (beat_q == LAST_BEAT) state_d = ST_DONE;
        else                     beat_d  = beat_q + CNT_W'(1);
      end
      ST_RD_BEATS: begin
        if (bus_io.rd_data_valid) begin
          rbuf_d[DATA_WIDTH*int'(beat_q) +: DATA_WIDTH] = bus_io.rd_data;
          if (beat_q == LAST_BEAT) begin
            rd_last = 1'b1;
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
`ifdef BURST_LINE_PORT_TIMEOUT_EN
        else if (timer_q >= TMR_W'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        resp_valid_c = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // state, request capture and the read line that is presented to the client
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      beat_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wline_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rbuf_q  <= rbuf_d;
      if (accept) begin
        wr_q    <= bus_io.req_write;
        addr_q  <= ADDR_WIDTH'(req_line) << BEAT_LOG;
        wline_q <= bus_io.req_wdata;
      end
      // the completed line becomes visible in the resp_valid cycle
      if (rd_last) rdata_q <= rbuf_d;
    end
  end

`ifdef BURST_LINE_PORT_TIMEOUT_EN
  // watchdog: counts cycles since the command was issued; flag latched on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE)         timer_q <= TMR_W'(1);
      else if (state_q == ST_RD_BEATS) timer_q <= timer_q + TMR_W'(1);
      if (state_q != ST_DONE) err_q <= timeout;
    end
  end

  assign bus_io.resp_err = (state_q == ST_DONE) && err_q;
`else
  assign bus_io.resp_err = 1'b0;
`endif

  assign bus_io.req_ready  = req_ready_c;
  assign bus_io.resp_valid = resp_valid_c;
  assign bus_io.resp_rdata = rdata_q;
  assign bus_io.cmd        = cmd_c;
  assign bus_io.cmd_en     = cmd_en_c;
  assign bus_io.addr       = addr_q;
  assign bus_io.wr_data    = wr_data_c;
  assign bus_io.data_mask  = '0;

endmodule

// File: tb/tb_burst_line_port.sv
// tb/tb_burst_line_port.sv - self-checking bench for burst_line_port with a BurstRAM behavioural model
module tb_burst_line_port;
  import burst_line_port_pkg::*;

  localparam int DW       = 64;
  localparam int BC       = 4;
  localparam int AW       = 4;
  localparam int LAW      = 2;
  localparam int LW       = DW * BC;
  localparam int DELAY    = 4;
  localparam int INIT_CYC = 6;

  localparam logic [63:0] INIT_MEM [8] = '{
    64'h3F5A2E14B7C6A980, 64'h9D8E2F17AB4C3E6F, 64'hA1C3F7E2D5B8A9C4, 64'h7D4E9F2C1B6A3D8F,
    64'h6C4B9A8D2F5E3C7A, 64'hE1A7D0B5C8F3E6A9, 64'hF8E9D2C3B4A5F6E7, 64'hD4E7F2C5B8A3D6E9
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  burst_line_port_if #(.DATA_WIDTH(DW), .BURST_COUNT(BC), .ADDR_WIDTH(AW)) bif ();

  burst_line_port #(.DATA_WIDTH(DW), .BURST_COUNT(BC), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bif)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- BurstRAM model ----------------
  logic [DW-1:0] ram [16];
  logic [AW-1:0] ptr;
  int   init_cnt, wr_left, rd_left, rd_cnt;
  logic stall = 1'b0;
  logic gap_en = 1'b0;
  logic extra_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt          <= INIT_CYC;
      bif.busy          <= 1'b1;
      bif.rd_data_valid <= 1'b0;
      bif.rd_data       <= '0;
      wr_left           <= 0;
      rd_left           <= 0;
      rd_cnt            <= 0;
      ptr               <= '0;
      for (int i = 0; i < 16; i++) ram[i] <= (i < 8) ? INIT_MEM[i % 8] : '0;
    end else begin
      bif.rd_data_valid <= 1'b0;
      if (init_cnt > 0) begin
        init_cnt <= init_cnt - 1;
        if (init_cnt == 1) bif.busy <= 1'b0;
      end else if (wr_left > 0) begin
        ram[ptr] <= bif.wr_data;
        ptr      <= ptr + 1'b1;
        wr_left  <= wr_left - 1;
        if (wr_left == 1) bif.busy <= 1'b0;
      end else if (rd_left > 0) begin
        rd_cnt <= rd_cnt + 1;
        if (rd_cnt >= DELAY - 1 && !(gap_en && rd_cnt[0])) begin
          bif.rd_data_valid <= 1'b1;
          bif.rd_data       <= ram[ptr];
          ptr               <= ptr + 1'b1;
          rd_left           <= rd_left - 1;
          if (rd_left == 1) bif.busy <= 1'b0;
        end
      end else if (bif.cmd_en && !bif.busy && !stall) begin
        bif.busy <= 1'b1;
        if (bif.cmd) begin
          ram[bif.addr] <= bif.wr_data;
          ptr           <= bif.addr + 1'b1;
          wr_left       <= BC - 1;
        end else begin
          ptr     <= bif.addr;
          rd_left <= extra_en ? BC + 1 : BC;
          rd_cnt  <= 0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [LW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [16];
  logic [LW-1:0] last_rd = '0;
  int            cmd_cnt = 0;
  int            resp_cnt = 0;
  logic          mon_active = 1'b0;
  logic          resp_due = 1'b0;
  int            mon_beats = 0;

  task automatic load_ref();
    for (int i = 0; i < 16; i++) ref_mem[i] = (i < 8) ? INIT_MEM[i % 8] : '0;
  endtask

  function automatic logic [LW-1:0] line_of(input int line);
    logic [LW-1:0] r;
    for (int b = 0; b < BC; b++) r[b*DW +: DW] = ref_mem[line*BC + b];
    return r;
  endfunction

  // observes the DUT away from the active edge; pops expectations on resp_valid
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      resp_due   = 1'b0;
    end else begin
      if (resp_due) begin
        checks++;
        if (bif.resp_valid !== 1'b1) begin
          errors++;
          $display("FAIL read_latency: resp_valid got %b expected 1 one cycle after last beat", bif.resp_valid);
        end
        resp_due = 1'b0;
      end
      if (bif.cmd_en) begin
        cmd_cnt++;
        checks++;
        if (bif.busy !== 1'b0) begin
          errors++;
          $display("FAIL cmd_overlap: busy got %b expected 0 at cmd_en", bif.busy);
        end
        if (bif.cmd == CMD_READ) begin
          mon_active = 1'b1;
          mon_beats  = 0;
        end
      end
      if (mon_active && bif.rd_data_valid) begin
        mon_beats++;
        if (mon_beats == BC) begin
          mon_active = 1'b0;
          resp_due   = 1'b1;
        end
      end
      if (bif.resp_valid) begin
        resp_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: resp_valid got 1 expected 0 (no request outstanding)");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bif.resp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL resp_rdata: got %h expected %h", bif.resp_rdata, e.rdata);
          end
          checks++;
          if (bif.resp_err !== e.err) begin
            errors++;
            $display("FAIL resp_err: got %b expected %b", bif.resp_err, e.err);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic w, input int line, input logic [LW-1:0] data,
                       input logic keep, input logic exp_err, output logic ok);
    exp_t e;
    bif.req_write = w;
    bif.req_addr  = LAW'(line);
    bif.req_wdata = data;
    bif.req_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (bif.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept: req_ready got %b expected 1 within 200 cycles", bif.req_ready);
      bif.req_valid = 1'b0;
      return;
    end
    if (exp_err) begin
      e.rdata = last_rd;
      e.err   = 1'b1;
    end else if (w) begin
      for (int b = 0; b < BC; b++) ref_mem[line*BC + b] = data[b*DW +: DW];
      e.rdata = last_rd;
      e.err   = 1'b0;
    end else begin
      e.rdata = line_of(line);
      e.err   = 1'b0;
      last_rd = e.rdata;
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (!keep) bif.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: outstanding responses got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({bif.req_ready, bif.resp_valid, bif.resp_err, bif.cmd, bif.cmd_en} !== 5'b0) begin
      errors++;
      $display("FAIL %s_ctrl: {ready,resp_valid,err,cmd,cmd_en} got %b expected 00000", tag,
               {bif.req_ready, bif.resp_valid, bif.resp_err, bif.cmd, bif.cmd_en});
    end
    checks++;
    if ({bif.addr, bif.wr_data, bif.data_mask} !== '0) begin
      errors++;
      $display("FAIL %s_ram: addr %h wr_data %h mask %h expected all 0", tag, bif.addr, bif.wr_data, bif.data_mask);
    end
    checks++;
    if (bif.resp_rdata !== '0) begin
      errors++;
      $display("FAIL %s_rdata: got %h expected 0", tag, bif.resp_rdata);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    n = 0;
    while (bif.busy === 1'b1 && n < 50) begin
      checks++;
      if (bif.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_while_busy: got %b expected 0", bif.req_ready);
      end
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (bif.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_init: got %b expected 1", bif.req_ready);
    end
  endtask

  task automatic test_read(input int line);
    logic ok;
    int   c0;
    c0 = cmd_cnt;
    issue(1'b0, line, '0, 1'b0, 1'b0, ok);
    if (ok) begin
      checks++;
      if ({bif.cmd_en, bif.cmd, bif.addr} !== {1'b1, CMD_READ, AW'(line*BC)}) begin
        errors++;
        $display("FAIL read_cmd: {cmd_en,cmd,addr} got %b expected %b",
                 {bif.cmd_en, bif.cmd, bif.addr}, {1'b1, CMD_READ, AW'(line*BC)});
      end
    end
    wait_drain();
    checks++;
    if (cmd_cnt - c0 != 1) begin
      errors++;
      $display("FAIL read_cmd_count: got %0d expected 1", cmd_cnt - c0);
    end
  endtask

  task automatic test_write_line();
    logic [LW-1:0] d;
    logic ok;
    for (int b = 0; b < BC; b++) d[b*DW +: DW] = {16{4'(b + 1)}};
    issue(1'b1, 2, d, 1'b0, 1'b0, ok);
    if (ok) begin
      checks++;
      if ({bif.cmd_en, bif.cmd, bif.addr, bif.data_mask} !== {1'b1, CMD_WRITE, 4'd8, 8'h00}) begin
        errors++;
        $display("FAIL write_cmd: {cmd_en,cmd,addr,mask} got %h expected %h",
                 {bif.cmd_en, bif.cmd, bif.addr, bif.data_mask}, {1'b1, CMD_WRITE, 4'd8, 8'h00});
      end
      for (int b = 0; b < BC; b++) begin
        if (b > 0) @(negedge clk);
        checks++;
        if (bif.wr_data !== d[b*DW +: DW] || (b > 0 && bif.cmd_en !== 1'b0)) begin
          errors++;
          $display("FAIL write_beat%0d: wr_data %h cmd_en %b expected %h", b, bif.wr_data, bif.cmd_en, d[b*DW +: DW]);
        end
      end
      @(negedge clk);
      checks++;
      if (bif.resp_valid !== 1'b1) begin
        errors++;
        $display("FAIL write_latency: resp_valid got %b expected 1 at accept+%0d", bif.resp_valid, BC + 1);
      end
    end
    wait_drain();
    test_read(2);
  endtask

  task automatic test_gap_extra();
    gap_en   = 1'b1;
    extra_en = 1'b1;
    test_read(1);
    gap_en   = 1'b0;
    extra_en = 1'b0;
    test_read(0);
  endtask

  task automatic test_back_to_back();
    logic ok;
    int   c0, r0;
    c0 = cmd_cnt;
    r0 = resp_cnt;
    issue(1'b0, 0, '0, 1'b1, 1'b0, ok);
    issue(1'b0, 1, '0, 1'b0, 1'b0, ok);
    wait_drain();
    checks++;
    if (cmd_cnt - c0 != 2 || resp_cnt - r0 != 2) begin
      errors++;
      $display("FAIL back_to_back: cmds %0d resps %0d expected 2 and 2", cmd_cnt - c0, resp_cnt - r0);
    end
  endtask

`ifdef BURST_LINE_PORT_TIMEOUT_EN
  task automatic test_timeout();
    logic ok;
    int   n;
    stall = 1'b1;
    issue(1'b0, 0, '0, 1'b0, 1'b1, ok);
    n = 0;
    while (bif.resp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles expected 64", n);
    end
    stall = 1'b0;
    wait_drain();
  endtask
`endif

  task automatic test_reset_mid_read();
    logic ok;
    int   r0;
    issue(1'b0, 1, '0, 1'b0, 1'b0, ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    last_rd = '0;
    load_ref();
    r0 = resp_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bif.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_abort: got %b expected 0", bif.req_ready);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (resp_cnt != r0) begin
      errors++;
      $display("FAIL abort_resp: got %0d responses expected 0", resp_cnt - r0);
    end
    test_read(0);
  endtask

  initial begin
    bif.req_valid = 1'b0;
    bif.req_write = 1'b0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    load_ref();
    test_reset();
    test_read(0);
    test_read(1);
    test_write_line();
    test_gap_extra();
    test_back_to_back();
`ifdef BURST_LINE_PORT_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
